cpu_control_unit: RTL
=====================

# cpu_control_unit

Multi-cycle control unit for the 8-bit processor: owns the program counter and sequences every instruction through fetch, decode, execute and optional memory/write-back phases. It drives the instruction ROM address, RAM address/write strobes, the ALU operation, the accumulator (`temp1`) load and the return-address stack. It consumes the ALU `carryOut`, a zero flag and the stack `empty`/`full` status.

## Interface
Parameters:
- `PC_W`, 8: program counter / ROM address width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `q_rom_inst`  in  13  ROM data; `[12:8]` opcode, `[7:0]` operand.
- `carry`  in  1  ALU carry (`carryOut`), sampled in EXECUTE.
- `zero`  in  1  accumulator == 0, sampled in EXECUTE.
- `stack_empty`  in  1  return stack empty.
- `stack_full`  in  1  return stack full.
- `stack_q`  in  PC_W  stack top, used by RET.
- `rom_addr`  out  PC_W  current PC.
- `ram_addr`  out  8  RAM address (operand).
- `ram_we`  out  1  RAM write strobe, one cycle.
- `alu_op`  out  3  0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR.
- `acc_we`  out  1  accumulator load strobe.
- `acc_sel`  out  2  accumulator source: 0 imm, 1 RAM, 2 ALU.
- `stack_push`  out  1  push strobe; `stack_din` = PC+1.
- `stack_pop`  out  1  pop strobe.
- `stack_din`  out  PC_W  push data.
- `halted`  out  1  core stopped.
- `fault`  out  1  stack guard tripped.

## Operation
- States: FETCH, DECODE, EXEC, MEMRD, WB, HALT, FAULT.
- FETCH: `rom_addr`=PC; next DECODE. DECODE: IR <= `q_rom_inst`; next EXEC.
- Opcodes: 0 NOP, 1 LDI, 2 LD, 3 ST, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 JMP, 9 JC, 10 JZ, 11 CALL, 12 RET, 31 HLT; all others execute as NOP.
- EXEC: LDI: `acc_sel`=0, `acc_we`; ST: `ram_addr`=operand, `ram_we`; ADD–OR: `alu_op`, `acc_sel`=2, `acc_we`; LD: `ram_addr`=operand, next MEMRD; JMP: PC<=operand; JC/JZ: PC<=operand if flag set, else PC+1; CALL: push PC+1, PC<=operand; RET: pop, PC<=`stack_q`; HLT: next HALT. All other cases PC<=PC+1, next FETCH.
- MEMRD: wait for synchronous RAM; next WB. WB: `acc_sel`=1, `acc_we`, PC+1, next FETCH.
- PC increments modulo 2^PC_W (255+1 -> 0).
- HALT and FAULT are absorbing; only reset exits.
- All strobes are Moore outputs, high for exactly one cycle.

## Timing
- Reset: PC=RESET_PC, state FETCH, every strobe 0, `alu_op`=0, `acc_sel`=0, `ram_addr`=0, `stack_din`=0, `halted`=0, `fault`=0; asserting reset mid-instruction clears strobes immediately.
- First FETCH is the first rising edge after reset release.
- Latency: 3 cycles per instruction; LD takes 5.
- ROM and RAM have 1-cycle read latency.
- `carry`/`zero` are sampled at the EXEC edge and reflect the previous instruction.
- `halted` rises in the cycle after the HLT EXEC.

## Configuration
- `CTRL_STACK_GUARD_EN` defined: CALL with `stack_full`=1 or RET with `stack_empty`=1 suppresses the strobe and PC update and enters FAULT, where `fault`=1 and `halted`=1.
- Without the macro: CALL and RET are issued unconditionally, and `fault` is tied to 0.

## Structure
- `cpu_ctrl_pkg`: opcode constants, state encoding, `alu_op` and `acc_sel` codes.
- Sub-module `program_counter`: holds the PC and supports reset, increment, load and hold.

## Test plan
- Reset, then LDI 0x05 at address 0: `acc_we` high in cycle 3 with `acc_sel`=0, and `rom_addr` becomes 1.
- LD 0x10 with RAM[0x10]=0x2A: `ram_addr`=0x10 in EXEC and `acc_we` with `acc_sel`=1 exactly 5 cycles after FETCH.
- JC 0x40 with `carry`=1, then with `carry`=0 from address 3: PC is 0x40 in the first case and 4 in the second.
- CALL 0x80 at address 0x07, then RET: `stack_push` with `stack_din`=0x08, then `stack_pop` and PC=0x08.
- With the guard macro, CALL while `stack_full`=1 gives no push and `fault`=`halted`=1; without the macro, the push occurs.
- HLT followed by reset asserted mid-cycle: `halted` clears asynchronously and the core restarts at PC=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control unit.
// Contents: opcode constants, FSM state encoding, ALU operation codes and
// accumulator source-select codes.
package cpu_ctrl_pkg;

  localparam int OPC_W = 5;
  localparam int OPD_W = 8;
  localparam int INST_W = OPC_W + OPD_W;

  localparam logic [OPC_W-1:0] OP_NOP  = 5'd0;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OPC_W-1:0] OP_LD   = 5'd2;
  localparam logic [OPC_W-1:0] OP_ST   = 5'd3;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd4;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd5;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd6;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd7;
  localparam logic [OPC_W-1:0] OP_JMP  = 5'd8;
  localparam logic [OPC_W-1:0] OP_JC   = 5'd9;
  localparam logic [OPC_W-1:0] OP_JZ   = 5'd10;
  localparam logic [OPC_W-1:0] OP_CALL = 5'd11;
  localparam logic [OPC_W-1:0] OP_RET  = 5'd12;
  localparam logic [OPC_W-1:0] OP_HLT  = 5'd31;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  localparam logic [1:0] ACC_IMM = 2'd0;
  localparam logic [1:0] ACC_RAM = 2'd1;
  localparam logic [1:0] ACC_ALU = 2'd2;

endpackage

// File: rtl/program_counter.sv
// Program counter register.
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset, loads RESET_PC
//   inc_i       advance PC by one (wraps modulo 2^PC_W)
//   load_i      load load_val_i (takes priority over inc_i)
//   load_val_i  jump / call / return target
//   pc_o        current PC
// With neither inc_i nor load_i the PC holds.
module program_counter #(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= PC_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for the 8-bit processor.
// Sequences each instruction FETCH -> DECODE -> EXEC (-> MEMRD -> WB for LD)
// and owns the program counter.
// Ports:
//   clk, reset (async, active-low)
//   q_rom_inst          ROM data, [12:8] opcode, [7:0] operand
//   carry, zero         ALU flags, sampled on the EXEC edge
//   stack_empty/full    return-stack status; stack_q = stack top for RET
//   rom_addr            current PC
//   ram_addr, ram_we    RAM address and one-cycle write strobe
//   alu_op              0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR
//   acc_we, acc_sel     accumulator load strobe / source (0 imm, 1 RAM, 2 ALU)
//   stack_push/pop      one-cycle stack strobes; stack_din = PC+1
//   halted, fault       core stopped / stack guard tripped
// Build option: define CTRL_STACK_GUARD_EN to block CALL on a full stack and
// RET on an empty stack, trapping into FAULT. Otherwise fault is tied to 0.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] q_rom_inst,
  input  logic              carry,
  input  logic              zero,
  input  logic              stack_empty,
  input  logic              stack_full,
  input  logic [PC_W-1:0]   stack_q,
  output logic [PC_W-1:0]   rom_addr,
  output logic [7:0]        ram_addr,
  output logic              ram_we,
  output logic [2:0]        alu_op,
  output logic              acc_we,
  output logic [1:0]        acc_sel,
  output logic              stack_push,
  output logic              stack_pop,
  output logic [PC_W-1:0]   stack_din,
  output logic              halted,
  output logic              fault
);

  state_e            state_q;
  logic [INST_W-1:0] ir_q;
  logic [7:0]        ram_addr_q;
  logic              ram_we_q;
  logic [2:0]        alu_op_q;
  logic              acc_we_q;
  logic [1:0]        acc_sel_q;
  logic              push_q;
  logic              pop_q;
  logic [PC_W-1:0]   stack_din_q;
  logic              halted_q;
  logic              guard_q;

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_plus1;
  logic              pc_inc_d;
  logic              pc_load_d;
  logic [PC_W-1:0]   pc_load_val_d;

  logic [OPC_W-1:0]  dec_op;
  logic [OPD_W-1:0]  dec_operand;
  logic [OPC_W-1:0]  ir_op;
  logic [OPD_W-1:0]  ir_operand;
  logic              guard_hit;

  assign dec_op      = q_rom_inst[INST_W-1:OPD_W];
  assign dec_operand = q_rom_inst[OPD_W-1:0];
  assign ir_op       = ir_q[INST_W-1:OPD_W];
  assign ir_operand  = ir_q[OPD_W-1:0];
  assign pc_plus1    = pc + PC_W'(1);

  // Guard is evaluated at DECODE so the stack strobe, which is registered on
  // that edge, can be suppressed before it ever reaches the stack.
`ifdef CTRL_STACK_GUARD_EN
  assign guard_hit = ((dec_op == OP_CALL) && stack_full) ||
                     ((dec_op == OP_RET)  && stack_empty);
`else
  logic unused_stack_status;
  assign unused_stack_status = stack_full ^ stack_empty;
  assign guard_hit = 1'b0;
  assign guard_q   = 1'b0;
`endif

  program_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i      (clk),
    .rst_ni     (reset),
    .inc_i      (pc_inc_d),
    .load_i     (pc_load_d),
    .load_val_i (pc_load_val_d),
    .pc_o       (pc)
  );

  // PC updates happen on the EXEC edge (or WB edge for LD), using the flags
  // present at that edge.
  always_comb begin
    pc_inc_d      = 1'b0;
    pc_load_d     = 1'b0;
    pc_load_val_d = PC_W'(ir_operand);
    if (state_q == ST_EXEC) begin
      case (ir_op)
        OP_LD, OP_HLT: ;
        OP_JMP:  pc_load_d = 1'b1;
        OP_JC:   begin pc_load_d = carry; pc_inc_d = !carry; end
        OP_JZ:   begin pc_load_d = zero;  pc_inc_d = !zero;  end
        OP_CALL: pc_load_d = !guard_q;
        OP_RET:  begin
          pc_load_d     = !guard_q;
          pc_load_val_d = stack_q;
        end
        default: pc_inc_d = 1'b1;
      endcase
    end else if (state_q == ST_WB) begin
      pc_inc_d = 1'b1;
    end
  end

`ifdef CTRL_STACK_GUARD_EN
  logic fault_q;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // Sequencer and registered outputs. Strobes default low every cycle and
  // are raised for the single following cycle, so they are one-shot Moore
  // outputs of the state they appear in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      ir_q        <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      alu_op_q    <= ALU_PASS;
      acc_we_q    <= 1'b0;
      acc_sel_q   <= ACC_IMM;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      stack_din_q <= '0;
      halted_q    <= 1'b0;
`ifdef CTRL_STACK_GUARD_EN
      guard_q     <= 1'b0;
      fault_q     <= 1'b0;
`endif
    end else begin
      ram_we_q <= 1'b0;
      acc_we_q <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      case (state_q)
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          ir_q     <= q_rom_inst;
          alu_op_q <= ALU_PASS;
          state_q  <= ST_EXEC;
`ifdef CTRL_STACK_GUARD_EN
          guard_q  <= guard_hit;
`endif
          case (dec_op)
            OP_LDI: begin
              acc_sel_q <= ACC_IMM;
              acc_we_q  <= 1'b1;
            end
            OP_LD:  ram_addr_q <= dec_operand;
            OP_ST: begin
              ram_addr_q <= dec_operand;
              ram_we_q   <= 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              case (dec_op)
                OP_ADD:  alu_op_q <= ALU_ADD;
                OP_SUB:  alu_op_q <= ALU_SUB;
                OP_AND:  alu_op_q <= ALU_AND;
                default: alu_op_q <= ALU_OR;
              endcase
              acc_sel_q <= ACC_ALU;
              acc_we_q  <= 1'b1;
            end
            OP_CALL: begin
              push_q      <= !guard_hit;
              stack_din_q <= pc_plus1;
            end
            OP_RET:  pop_q <= !guard_hit;
            default: ;
          endcase
        end
        ST_EXEC: begin
          if (ir_op == OP_LD) begin
            state_q <= ST_MEMRD;
          end else if (ir_op == OP_HLT) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
`ifdef CTRL_STACK_GUARD_EN
          end else if (guard_q) begin
            state_q  <= ST_FAULT;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
`endif
          end else begin
            state_q <= ST_FETCH;
          end
        end
        // RAM data becomes valid one cycle after the EXEC address.
        ST_MEMRD: begin
          acc_sel_q <= ACC_RAM;
          acc_we_q  <= 1'b1;
          state_q   <= ST_WB;
        end
        ST_WB:    state_q <= ST_FETCH;
        ST_HALT:  state_q <= ST_HALT;
        ST_FAULT: state_q <= ST_FAULT;
        default:  state_q <= ST_FETCH;
      endcase
    end
  end

  assign rom_addr   = pc;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign alu_op     = alu_op_q;
  assign acc_we     = acc_we_q;
  assign acc_sel    = acc_sel_q;
  assign stack_push = push_q;
  assign stack_pop  = pop_q;
  assign stack_din  = stack_din_q;
  assign halted     = halted_q;

endmodule
